imem_uart_loader: RTL and testbench
===================================

// Module: imem_uart_loader
// PURPOSE
//  - Debug-unit program loader. Fed by the debug command decoder, which pulses i_start once it has consumed command 0x07.
//  - Pops bytes from the UART RX FIFO: a count byte N, then N instructions of 4 bytes each, least-significant byte first.
//  - Assembles each instruction word and writes it to instruction memory at consecutive word slots from 0.
//  - On finish, pushes an ack byte ('R' or 'E') into the UART TX FIFO.
//  - Holds o_busy high throughout; the top level uses it to stall the core.
// PARAMETERS
//  SIZE             32  instruction word width
//  ADDR_WIDTH       32  instruction-memory byte-address width
//  MAX_INSTRUCTION  64  instruction-memory depth, in words
//  ACK_OK           8'h52  ('R') ack byte on success
//  ACK_ERR          8'h45  ('E') ack byte on rejected count
// PORTS
//  i_clk         in   1           system clock
//  i_rst_n       in   1           synchronous reset, active low
//  i_start       in   1           1-cycle pulse: begin a load
//  i_rx_empty    in   1           RX FIFO empty
//  i_rx_data     in   8           RX FIFO head byte (first-word-fall-through)
//  o_rd          out  1           pop RX FIFO head this cycle
//  i_tx_full     in   1           TX FIFO full
//  o_tx_wr       out  1           push o_tx_data this cycle
//  o_tx_data     out  8           ack byte
//  o_imem_we     out  1           instruction-memory write strobe
//  o_imem_addr   out  ADDR_WIDTH  byte address = word_index*4
//  o_imem_data   out  SIZE        instruction word
//  o_busy        out  1           high from accepted i_start until the ack push
//  o_done        out  1           1-cycle pulse in the cycle of the ack push
//  o_err         out  1           sticky: last load was rejected; cleared by the next accepted i_start
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low.
//  - Reset (i_rst_n=0 at a posedge): state IDLE, all outputs 0, counters 0. Applies mid-load; partial words are discarded.
//  - FSM states: IDLE, GET_COUNT, GET_BYTE, WRITE, [APPEND], ACK.
//  - IDLE: i_start=1 -> GET_COUNT, o_busy=1, o_err=0. i_start outside IDLE is ignored.
//  - Pop rule, GET_COUNT/GET_BYTE only: o_rd = !i_rx_empty, combinational. i_rx_data is captured in that same cycle. At most one byte per cycle; stall indefinitely while empty.
//  - GET_COUNT on pop:
//    - N=0 -> ACK with ACK_OK.
//    - N>MAX_INSTRUCTION -> ACK with ACK_ERR, o_err=1; no writes, no further pops.
//    - Otherwise -> GET_BYTE, word_idx=0, byte_idx=0.
//  - GET_BYTE: pop k (k=0..3) fills word bits [8k+7:8k]. After pop 3 -> WRITE.
//  - WRITE: one cycle, o_imem_we=1, addr=word_idx<<2, data=assembled word.
//    - word_idx+1==N -> APPEND if enabled, else ACK.
//    - Otherwise word_idx++ and -> GET_BYTE.
//  - Write latency: o_imem_we is asserted in the cycle after the 4th byte's pop. Sustained rate is one word per 5 cycles.
//  - ACK: o_tx_wr = !i_tx_full. On push -> IDLE, o_busy=0, o_done=1 in the push cycle. Hold the ack byte while i_tx_full=1.
//  - Bytes beyond 4N stay in the RX FIFO for the command decoder. The loader never pops in IDLE or ACK.
//  - o_imem_we, o_rd and o_tx_wr are never asserted in the same cycle.
// CONFIGURATION
//  - LOADER_HALT_APPEND_EN defined: after the last WRITE, and only when N<MAX_INSTRUCTION, an APPEND state writes SIZE'hFFFF_FFFF (HALT) at word N, then -> ACK. It is skipped for N=0, N=MAX, and rejected loads.
//  - Undefined: the APPEND state does not exist; WRITE goes directly to ACK.
// STRUCTURE
//  - Shared package (debug-unit package):
//    - loader state enum
//    - CMD_LOAD=8'h07
//    - ACK_OK/ACK_ERR values
//    - HALT_WORD
//    - IDX_W=$clog2(MAX_INSTRUCTION+1)
//  - Single module, no sub-modules. The byte assembler is a 4x8 shift register inside the FSM.
// TESTING
//  1. Start; FIFO holds 02, 01 00 01 3C, 03 00 03 3C.
//     -> writes (0x0, 3C010001), then (0x4, 3C030003); then 'R'; o_done one pulse.
//  2. Start; count 00 -> no writes; 'R' pushed; o_err=0.
//  3. Start; count 8'd65 -> no writes, no further pops; 'E' pushed; o_err=1.
//     Next start with count 01 -> o_err clears.
//  4. rx_empty toggled 1/0 every cycle during a 1-word load -> o_rd only when !rx_empty; word still 3C010001.
//     i_tx_full held 1 for 20 cycles -> ack pushed exactly once, after release.
//  5. i_rst_n=0 after the 2nd byte of word 1 -> all outputs 0 next cycle.
//     A new start plus a 1-word load then writes addr 0x0 correctly.
//  6. i_start re-pulsed mid-load -> ignored.
//     With LOADER_HALT_APPEND_EN, N=2 -> third write (0x8, FFFFFFFF) precedes 'R'.

Source files
------------

// File: rtl/imem_uart_loader_pkg.sv
// Debug-unit shared definitions for the instruction-memory UART loader.
// LOADER_HALT_APPEND_EN adds the APPEND state to the loader state enum.
package imem_uart_loader_pkg;

  localparam int SIZE            = 32;
  localparam int ADDR_WIDTH      = 32;
  localparam int MAX_INSTRUCTION = 64;
  localparam int IDX_W           = $clog2(MAX_INSTRUCTION + 1);

  localparam logic [7:0] CMD_LOAD  = 8'h07;
  localparam logic [7:0] ACK_OK    = 8'h52;
  localparam logic [7:0] ACK_ERR   = 8'h45;
  localparam logic [7:0] MAX_COUNT = 8'(MAX_INSTRUCTION);

  localparam logic [SIZE-1:0] HALT_WORD = {SIZE{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_COUNT = 3'd1,
    ST_GET_BYTE  = 3'd2,
    ST_WRITE     = 3'd3,
`ifdef LOADER_HALT_APPEND_EN
    ST_APPEND    = 3'd4,
`endif
    ST_ACK       = 3'd5
  } loader_state_t;

  // Word slot index to instruction-memory byte address.
  function automatic logic [ADDR_WIDTH-1:0] word_byte_addr(input logic [IDX_W-1:0] idx);
    return ADDR_WIDTH'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/imem_uart_loader.sv
// Instruction-memory program loader driven from the UART RX/TX FIFOs.
// Reads a count byte N and N little-endian 32-bit words, writes them to
// consecutive word slots from 0, then pushes an 'R' / 'E' ack byte.
// Optional build macro: LOADER_HALT_APPEND_EN (writes a HALT word at slot N
// after the last instruction when N is below the memory depth).
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | waiting for i_start; nothing popped or pushed
//  GET_COUNT  | popping the count byte N
//  GET_BYTE   | popping the 4 bytes of the current word, LSB first
//  WRITE      | one-cycle write of the assembled word at word_idx*4
//  APPEND     | one-cycle HALT write at N*4 (macro builds only)
//  ACK        | pushing the ack byte, waiting out a full TX FIFO
module imem_uart_loader
  import imem_uart_loader_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_rx_empty,
  input  logic [7:0]            i_rx_data,
  output logic                  o_rd,
  input  logic                  i_tx_full,
  output logic                  o_tx_wr,
  output logic [7:0]            o_tx_data,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [SIZE-1:0]       o_imem_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  loader_state_t state_q, state_d;

  logic [SIZE-1:0]  word_q;
  logic [1:0]       byte_idx_q;
  logic [IDX_W-1:0] word_idx_q;
  logic [IDX_W-1:0] count_q;
  logic [7:0]       ack_q;
  logic             err_q;

  logic count_zero;
  logic count_bad;
  logic last_word;

  assign count_zero = (i_rx_data == 8'h00);
  assign count_bad  = (i_rx_data > MAX_COUNT);
  assign last_word  = ((word_idx_q + IDX_W'(1)) == count_q);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_GET_COUNT;
      end
      ST_GET_COUNT: begin
        if (!i_rx_empty) begin
          if (count_zero || count_bad) state_d = ST_ACK;
          else                         state_d = ST_GET_BYTE;
        end
      end
      ST_GET_BYTE: begin
        if (!i_rx_empty && (byte_idx_q == 2'd3)) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (last_word) begin
`ifdef LOADER_HALT_APPEND_EN
          // A full memory has no free slot for the HALT word.
          if (count_q < IDX_W'(MAX_INSTRUCTION)) state_d = ST_APPEND;
          else                                   state_d = ST_ACK;
`else
          state_d = ST_ACK;
`endif
        end else begin
          state_d = ST_GET_BYTE;
        end
      end
`ifdef LOADER_HALT_APPEND_EN
      ST_APPEND: begin
        state_d = ST_ACK;
      end
`endif
      ST_ACK: begin
        if (!i_tx_full) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes and write bus; the address/data bus is zero outside write cycles.
  always_comb begin
    o_rd        = 1'b0;
    o_imem_we   = 1'b0;
    o_imem_addr = '0;
    o_imem_data = '0;
    o_tx_wr     = 1'b0;
    o_done      = 1'b0;
    case (state_q)
      ST_GET_COUNT, ST_GET_BYTE: begin
        o_rd = !i_rx_empty;
      end
      ST_WRITE: begin
        o_imem_we   = 1'b1;
        o_imem_addr = word_byte_addr(word_idx_q);
        o_imem_data = word_q;
      end
`ifdef LOADER_HALT_APPEND_EN
      ST_APPEND: begin
        o_imem_we   = 1'b1;
        o_imem_addr = word_byte_addr(count_q);
        o_imem_data = HALT_WORD;
      end
`endif
      ST_ACK: begin
        o_tx_wr = !i_tx_full;
        o_done  = !i_tx_full;
      end
      default: begin
      end
    endcase
    o_busy    = (state_q != ST_IDLE);
    o_tx_data = ack_q;
    o_err     = err_q;
  end

  // Count capture, byte assembly, word index and sticky error flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      word_q     <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      count_q    <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) err_q <= 1'b0;
        end
        ST_GET_COUNT: begin
          if (!i_rx_empty) begin
            word_idx_q <= '0;
            byte_idx_q <= '0;
            if (count_bad) begin
              count_q <= '0;
              ack_q   <= ACK_ERR;
              err_q   <= 1'b1;
            end else begin
              count_q <= i_rx_data[IDX_W-1:0];
              ack_q   <= ACK_OK;
            end
          end
        end
        ST_GET_BYTE: begin
          // Shift in from the top so the first byte ends up in bits [7:0].
          if (!i_rx_empty) begin
            word_q     <= {i_rx_data, word_q[SIZE-1:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
          end
        end
        ST_WRITE: begin
          if (!last_word) word_idx_q <= word_idx_q + IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: a transaction-level model tracks
// bytes consumed, words written and ack status, and every cycle the DUT's
// strobes and buses are compared against what those counts imply.
// Honours LOADER_HALT_APPEND_EN when the design is built with it.
module tb_imem_uart_loader;

`ifdef LOADER_HALT_APPEND_EN
  localparam bit APPEND = 1'b1;
`else
  localparam bit APPEND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst_n, i_start, i_rx_empty, i_tx_full;
  logic [7:0]  i_rx_data;
  logic        o_rd, o_tx_wr, o_imem_we, o_busy, o_done, o_err;
  logic [7:0]  o_tx_data;
  logic [31:0] o_imem_addr, o_imem_data;

  always #5 clk = ~clk;

  imem_uart_loader dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_rx_empty(i_rx_empty), .i_rx_data(i_rx_data), .o_rd(o_rd),
    .i_tx_full(i_tx_full), .o_tx_wr(o_tx_wr), .o_tx_data(o_tx_data),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int nvec = 0;
  int nmis = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] popped[$];

  bit         m_active, m_err, m_valid;
  int         m_pops, m_total, m_writes, m_total_writes, m_n;
  logic [7:0] m_ack;

  bit drv_rst_n = 1'b0;
  bit drv_start = 1'b0;
  int stall_mode = 0;
  int full_mode = 0;
  int full_hold = 0;
  int stepn = 0;

  logic [63:0] wr_log[$];
  logic [7:0]  ack_log[$];
  int rd_cnt, done_cnt;

  function automatic int wc(input int p);
    return (p >= 1) ? (p - 1) / 4 : 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, compare, then advance the model.
  task automatic step();
    bit          empty_d, full_d, e_rd, e_we, e_tx, start_acc;
    int          avail, w;
    logic [63:0] ew;
    logic [7:0]  b;
    @(negedge clk);
    stepn++;
    i_rst_n = drv_rst_n;
    i_start = drv_start;
    empty_d = (fifo_q.size() == 0) || (stall_mode == 1 && $urandom_range(0, 9) < 3) ||
              (stall_mode == 2 && stepn[0]);
    i_rx_empty = empty_d;
    i_rx_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
    full_d = (full_hold > 0) || (full_mode == 1 && $urandom_range(0, 9) < 3);
    if (full_hold > 0) full_hold--;
    i_tx_full = full_d;
    #1;
    if (o_imem_we) wr_log.push_back({o_imem_addr, o_imem_data});
    if (o_tx_wr) ack_log.push_back(o_tx_data);
    if (o_rd) rd_cnt++;
    if (o_done) done_cnt++;
    if (!drv_rst_n) begin
      m_active  = 1'b0;
      m_err     = 1'b0;
      drv_start = 1'b0;
      return;
    end
    avail = wc(m_pops) + ((APPEND && m_valid && m_n < 64 && m_writes >= m_n) ? 1 : 0);
    e_rd = m_active && (m_pops < m_total) && (m_writes == wc(m_pops)) && !empty_d;
    e_we = m_active && (m_writes < avail);
    e_tx = m_active && (m_pops == m_total) && (m_writes == m_total_writes) && !full_d;
    chk("rd", o_rd, e_rd);
    chk("imem_we", o_imem_we, e_we);
    chk("tx_wr", o_tx_wr, e_tx);
    chk("done", o_done, e_tx);
    chk("busy", o_busy, m_active);
    chk("err", o_err, m_err);
    chk("exclusive", 64'($countones({o_rd, o_imem_we, o_tx_wr}) > 1), 64'd0);
    if (e_we) begin
      w = m_writes;
      if (w == m_n) ew = {32'(4 * w), 32'hFFFF_FFFF};
      else ew = {32'(4 * w), popped[4*w+4], popped[4*w+3], popped[4*w+2], popped[4*w+1]};
      chk("imem_word", {o_imem_addr, o_imem_data}, ew);
    end
    if (e_tx) chk("ack_byte", 64'(o_tx_data), 64'(m_ack));
    start_acc = drv_start && !m_active;
    if (e_rd) begin
      b = fifo_q.pop_front();
      popped.push_back(b);
      if (m_pops == 0) begin
        if (b == 8'd0) begin
          m_n = 0; m_valid = 1'b0; m_total = 1; m_total_writes = 0; m_ack = 8'h52;
        end else if (b > 8'd64) begin
          m_n = 0; m_valid = 1'b0; m_total = 1; m_total_writes = 0; m_ack = 8'h45; m_err = 1'b1;
        end else begin
          m_n = int'(b); m_valid = 1'b1; m_total = 1 + 4 * m_n;
          m_total_writes = m_n + ((APPEND && m_n < 64) ? 1 : 0);
          m_ack = 8'h52;
        end
      end
      m_pops++;
    end
    if (e_we) m_writes++;
    if (e_tx) m_active = 1'b0;
    if (start_acc) begin
      m_active = 1'b1; m_err = 1'b0; m_valid = 1'b0; m_n = 0;
      m_pops = 0; m_total = 1; m_writes = 0; m_total_writes = 0;
      popped.delete();
    end
    drv_start = 1'b0;
  endtask

  task automatic clear_logs();
    wr_log.delete(); ack_log.delete(); rd_cnt = 0; done_cnt = 0;
  endtask

  // Start a load from the bytes already in fifo_q and run it to its ack.
  task automatic load(input int restart_at);
    clear_logs();
    drv_start = 1'b1;
    step();
    for (int i = 0; i < 3000 && m_active; i++) begin
      if (i == restart_at) drv_start = 1'b1;
      step();
    end
    nvec++;
    if (m_active) begin
      nmis++;
      $display("FAIL load_timeout: loader still busy after 3000 cycles");
    end
  endtask

  function automatic logic [63:0] wr_at(input int idx);
    return (idx < wr_log.size()) ? wr_log[idx] : 64'hXXXX_XXXX_XXXX_XXXX;
  endfunction

  initial begin
    int n, trail, exp_pops, exp_wr;
    i_rst_n = 1'b0; i_start = 1'b0; i_rx_empty = 1'b1; i_rx_data = '0; i_tx_full = 1'b0;

    repeat (3) step();
    drv_rst_n = 1'b1;
    step();
    chk("rst_outputs", {o_rd, o_tx_wr, o_imem_we, o_busy, o_done, o_err},  6'b0);
    chk("rst_buses", {o_imem_addr, o_imem_data}, 64'd0);
    chk("rst_tx_data", o_tx_data, 8'd0);

    // Two-word program.
    fifo_q = '{8'h02, 8'h01, 8'h00, 8'h01, 8'h3C, 8'h03, 8'h00, 8'h03, 8'h3C};
    load(-1);
    chk("t1_nwrites", wr_log.size(), APPEND ? 3 : 2);
    chk("t1_wr0", wr_at(0), {32'h0, 32'h3C01_0001});
    chk("t1_wr1", wr_at(1), {32'h4, 32'h3C03_0003});
    chk("t1_ack", {24'd0, ack_log.size() == 1 ? ack_log[0] : 8'hXX}, 32'h52);
    chk("t1_done_pulses", done_cnt, 1);

    // Zero count.
    fifo_q = '{8'h00};
    load(-1);
    chk("t2_nwrites", wr_log.size(), 0);
    chk("t2_ack", {24'd0, ack_log.size() == 1 ? ack_log[0] : 8'hXX}, 32'h52);
    chk("t2_err", o_err, 1'b0);

    // Rejected count; trailing bytes must stay put.
    fifo_q = '{8'd65, 8'h01, 8'h02, 8'h03, 8'h04};
    load(-1);
    chk("t3_nwrites", wr_log.size(), 0);
    chk("t3_pops", rd_cnt, 1);
    chk("t3_ack", {24'd0, ack_log.size() == 1 ? ack_log[0] : 8'hXX}, 32'h45);
    chk("t3_err_set", o_err, 1'b1);
    fifo_q = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    load(-1);
    chk("t3_err_clear", o_err, 1'b0);
    chk("t3_wr0", wr_at(0), {32'h0, 32'h4433_2211});

    // Toggling RX empty and a TX FIFO held full for 20 cycles.
    stall_mode = 2;
    full_hold = 20;
    fifo_q = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h3C};
    load(-1);
    stall_mode = 0;
    chk("t4_wr0", wr_at(0), {32'h0, 32'h3C01_0001});
    chk("t4_pops", rd_cnt, 5);
    chk("t4_ack_count", ack_log.size(), 1);

    // Reset after the 2nd byte of word 1, then a clean 1-word load.
    fifo_q = '{8'h02, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    clear_logs();
    drv_start = 1'b1;
    step();
    for (int i = 0; i < 200 && m_pops < 7; i++) step();
    drv_rst_n = 1'b0;
    step();
    drv_rst_n = 1'b1;
    step();
    chk("t5_outputs", {o_rd, o_tx_wr, o_imem_we, o_busy, o_done, o_err}, 6'b0);
    chk("t5_buses", {o_imem_addr, o_imem_data, o_tx_data}, 72'd0);
    fifo_q = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h3C};
    load(-1);
    chk("t5_wr0", wr_at(0), {32'h0, 32'h3C01_0001});

    // Re-pulsed start mid-load is ignored.
    fifo_q = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h90};
    load(4);
    chk("t6_nwrites", wr_log.size(), APPEND ? 3 : 2);
    chk("t6_wr0", wr_at(0), {32'h0, 32'h1234_5678});
    chk("t6_wr1", wr_at(1), {32'h4, 32'h90AB_CDEF});
    if (APPEND) chk("t6_halt", wr_at(2), {32'h8, 32'hFFFF_FFFF});
    chk("t6_ack_count", ack_log.size(), 1);

    // Randomised loads with random RX stalls and TX back-pressure.
    stall_mode = 1;
    full_mode = 1;
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 5))
        0: n = $urandom_range(0, 3);
        1: n = 64;
        2: n = $urandom_range(65, 255);
        default: n = $urandom_range(1, 40);
      endcase
      fifo_q.delete();
      fifo_q.push_back(8'(n));
      if (n >= 1 && n <= 64)
        for (int k = 0; k < 4 * n; k++) fifo_q.push_back(8'($urandom));
      trail = $urandom_range(0, 3);
      for (int k = 0; k < trail; k++) fifo_q.push_back(8'($urandom));
      load(($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1);
      exp_pops = (n >= 1 && n <= 64) ? 1 + 4 * n : 1;
      exp_wr = (n >= 1 && n <= 64) ? n + ((APPEND && n < 64) ? 1 : 0) : 0;
      chk("rand_pops", rd_cnt, exp_pops);
      chk("rand_nwrites", wr_log.size(), exp_wr);
      chk("rand_ack_count", ack_log.size(), 1);
      chk("rand_err", o_err, n > 64);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
